// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS stopwatch core.
// Consumes the divider's 1 Hz / 2 Hz (and 4 Hz blink) square waves as data
// levels and edge-detects them on the system clock. Modes: RUN counts on the
// 1 Hz edge, HOLD freezes, ADJ bumps the field picked by sel on the 2 Hz edge.
// Optional feature: define BLINK_EN to blank the selected field in ADJ at the
// clk_blink rate. With BLINK_EN undefined the blank outputs are tied to 0.
module stopwatch_counter #(
   parameter int unsigned MIN_MAX      = 99,   // highest minutes value, 1..99
   parameter bit          START_PAUSED = 1'b1  // 1: come out of reset in HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_1hz,
   input  logic       clk_2hz,
   input  logic       clk_blink,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       min_blank,
   output logic       sec_blank
);

   // Minutes wrap point split into BCD digits.
   localparam logic [3:0] MIN_T = 4'(MIN_MAX / 10);
   localparam logic [3:0] MIN_O = 4'(MIN_MAX % 10);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_ADJ  = 2'd2
   } state_e;

   state_e     state_q;
   logic       pause_saved_q;
   logic       running_q;
   logic       saved_tog;

   logic       prev_1hz_q, prev_2hz_q;
   logic       tick_1hz_q, tick_2hz_q;
   logic       tick_1hz_d, tick_2hz_d;

   logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
   logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

   // Incremented candidates for each field.
   logic [3:0] sec_tens_inc, sec_ones_inc, min_tens_inc, min_ones_inc;
   logic       sec_carry;

   // Rising-edge detect on the divider levels; ticks are registered so a tick
   // is one cycle wide and lags the sampled input edge by one cycle.
   always_comb begin
      tick_1hz_d = clk_1hz & ~prev_1hz_q;
      tick_2hz_d = clk_2hz & ~prev_2hz_q;
   end

   // Edge-detect history and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_1hz_q <= 1'b0;
         prev_2hz_q <= 1'b0;
         tick_1hz_q <= 1'b0;
         tick_2hz_q <= 1'b0;
      end else begin
         prev_1hz_q <= clk_1hz;
         prev_2hz_q <= clk_2hz;
         tick_1hz_q <= tick_1hz_d;
         tick_2hz_q <= tick_2hz_d;
      end
   end

   // A pause pulse always lands in pause_saved when it is captured, so the
   // ADJ exit decision uses the post-toggle value.
   always_comb saved_tog = pause_saved_q ^ pause;

   // Mode FSM: adj beats pause in RUN/HOLD, but the pause pulse is still folded
   // into pause_saved on the entry cycle. running is a registered decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= START_PAUSED ? ST_HOLD : ST_RUN;
         pause_saved_q <= START_PAUSED;
         running_q     <= ~START_PAUSED;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (adj) begin
                  state_q       <= ST_ADJ;
                  pause_saved_q <= pause;      // 0 toggled by a coincident pulse
                  running_q     <= 1'b0;
               end else if (pause) begin
                  state_q   <= ST_HOLD;
                  running_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (adj) begin
                  state_q       <= ST_ADJ;
                  pause_saved_q <= ~pause;     // 1 toggled by a coincident pulse
               end else if (pause) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            ST_ADJ: begin
               pause_saved_q <= saved_tog;
               if (!adj) begin
                  state_q   <= saved_tog ? ST_HOLD : ST_RUN;
                  running_q <= ~saved_tog;
               end
            end
            default: begin
               state_q   <= ST_HOLD;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   // Per-field BCD increment candidates with their wrap points.
   always_comb begin
      sec_carry = 1'b0;
      if (sec_ones_q == 4'd9) begin
         sec_ones_inc = 4'd0;
         if (sec_tens_q == 4'd5) begin
            sec_tens_inc = 4'd0;
            sec_carry    = 1'b1;
         end else begin
            sec_tens_inc = sec_tens_q + 4'd1;
         end
      end else begin
         sec_ones_inc = sec_ones_q + 4'd1;
         sec_tens_inc = sec_tens_q;
      end

      if (min_tens_q == MIN_T && min_ones_q == MIN_O) begin
         min_tens_inc = 4'd0;
         min_ones_inc = 4'd0;
      end else if (min_ones_q == 4'd9) begin
         min_tens_inc = min_tens_q + 4'd1;
         min_ones_inc = 4'd0;
      end else begin
         min_tens_inc = min_tens_q;
         min_ones_inc = min_ones_q + 4'd1;
      end
   end

   // Next digits: RUN counts with carry on tick_1hz, ADJ bumps one field on
   // tick_2hz with no carry. Only the tick that matches the registered state acts.
   always_comb begin
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      min_tens_d = min_tens_q;
      case (state_q)
         ST_RUN: begin
            if (tick_1hz_q) begin
               sec_ones_d = sec_ones_inc;
               sec_tens_d = sec_tens_inc;
               if (sec_carry) begin
                  min_ones_d = min_ones_inc;
                  min_tens_d = min_tens_inc;
               end
            end
         end
         ST_ADJ: begin
            if (tick_2hz_q) begin
               if (sel) begin
                  sec_ones_d = sec_ones_inc;
                  sec_tens_d = sec_tens_inc;
               end else begin
                  min_ones_d = min_ones_inc;
                  min_tens_d = min_tens_inc;
               end
            end
         end
         default: ;
      endcase
   end

   // Digit registers; reset discards the count immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_ones_q <= 4'd0;
         sec_tens_q <= 4'd0;
         min_ones_q <= 4'd0;
         min_tens_q <= 4'd0;
      end else begin
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         min_tens_q <= min_tens_d;
      end
   end

`ifdef BLINK_EN
   logic prev_blink_q, tick_blink_q, tick_blink_d;
   logic phase_q, phase_d;

   // Blink edge detect and phase; phase is held at 0 outside ADJ so every ADJ
   // entry starts with the field visible.
   always_comb begin
      tick_blink_d = clk_blink & ~prev_blink_q;
      phase_d      = phase_q;
      if (state_q != ST_ADJ)
         phase_d = 1'b0;
      else if (tick_blink_q)
         phase_d = ~phase_q;
   end

   // Blink history, tick and phase registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_blink_q <= 1'b0;
         tick_blink_q <= 1'b0;
         phase_q      <= 1'b0;
      end else begin
         prev_blink_q <= clk_blink;
         tick_blink_q <= tick_blink_d;
         phase_q      <= phase_d;
      end
   end

   assign min_blank = (state_q == ST_ADJ) & ~sel & phase_q;
   assign sec_blank = (state_q == ST_ADJ) &  sel & phase_q;
`else
   logic unused_blink;
   assign unused_blink = clk_blink;
   assign min_blank    = 1'b0;
   assign sec_blank    = 1'b0;
`endif

   assign min_tens = min_tens_q;
   assign min_ones = min_ones_q;
   assign sec_tens = sec_tens_q;
   assign sec_ones = sec_ones_q;
   assign running  = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed steps followed by a random phase, checked
// every cycle against an integer minutes/seconds reference model.
module tb_stopwatch_counter;

   localparam int unsigned MIN_MAX      = 99;
   localparam bit          START_PAUSED = 1'b1;

   localparam int S_RUN  = 0;
   localparam int S_HOLD = 1;
   localparam int S_ADJ  = 2;

   logic       clk = 1'b0;
   logic       rst_n, clk_1hz, clk_2hz, clk_blink, pause, adj, sel;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, min_blank, sec_blank;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: time as plain integers, mode as a small int.
   int m_min, m_sec, m_state;
   bit m_saved;
   bit m_prev1, m_prev2, m_prevb;
   bit m_rise1, m_rise2, m_riseb;   // edges seen on the previous clock
   bit m_phase;

   stopwatch_counter #(.MIN_MAX(MIN_MAX), .START_PAUSED(START_PAUSED)) dut (
      .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .clk_2hz(clk_2hz),
      .clk_blink(clk_blink), .pause(pause), .adj(adj), .sel(sel),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .running(running), .min_blank(min_blank),
      .sec_blank(sec_blank)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_min = 0; m_sec = 0;
      m_state = START_PAUSED ? S_HOLD : S_RUN;
      m_saved = START_PAUSED;
      m_prev1 = 0; m_prev2 = 0; m_prevb = 0;
      m_rise1 = 0; m_rise2 = 0; m_riseb = 0;
      m_phase = 0;
   endtask

   // One clock of the model using the inputs present at the edge.
   task automatic model_step();
      if (m_state == S_RUN && m_rise1) begin
         m_sec = m_sec + 1;
         if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % (MIN_MAX + 1);
         end
      end else if (m_state == S_ADJ && m_rise2) begin
         if (sel) m_sec = (m_sec + 1) % 60;
         else     m_min = (m_min + 1) % (MIN_MAX + 1);
      end
      if (m_state != S_ADJ) m_phase = 0;
      else if (m_riseb)     m_phase = !m_phase;
      if (m_state == S_ADJ) begin
         m_saved = m_saved ^ pause;
         if (!adj) m_state = m_saved ? S_HOLD : S_RUN;
      end else if (adj) begin
         m_saved = (m_state == S_HOLD) ^ pause;
         m_state = S_ADJ;
      end else if (pause) begin
         m_state = (m_state == S_RUN) ? S_HOLD : S_RUN;
      end
      m_rise1 = clk_1hz   && !m_prev1; m_prev1 = clk_1hz;
      m_rise2 = clk_2hz   && !m_prev2; m_prev2 = clk_2hz;
      m_riseb = clk_blink && !m_prevb; m_prevb = clk_blink;
   endtask

   task automatic check(input string tag);
      logic [18:0] got, exp;
      bit eb_min, eb_sec;
`ifdef BLINK_EN
      eb_min = (m_state == S_ADJ) && !sel && m_phase;
      eb_sec = (m_state == S_ADJ) &&  sel && m_phase;
`else
      eb_min = 0; eb_sec = 0;
`endif
      got = {min_tens, min_ones, sec_tens, sec_ones, running, min_blank, sec_blank};
      exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
             m_state == S_RUN, eb_min, eb_sec};
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   // Explicit spot check against hand-derived constants.
   task automatic check_time(input string tag, input int mm, input int ss, input bit run);
      logic [16:0] got, exp;
      got = {min_tens, min_ones, sec_tens, sec_ones, running};
      exp = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run};
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      #1 check(tag);
   endtask

   task automatic rise1(input string tag);
      clk_1hz = 1; cyc(tag); cyc(tag);
      clk_1hz = 0; cyc(tag); cyc(tag);
   endtask

   task automatic rise2(input string tag);
      clk_2hz = 1; cyc(tag); cyc(tag);
      clk_2hz = 0; cyc(tag); cyc(tag);
   endtask

   task automatic pulse_pause(input string tag);
      pause = 1; cyc(tag);
      pause = 0;
   endtask

   initial begin
      logic [3:0] blank_exp;
      rst_n = 0; clk_1hz = 0; clk_2hz = 0; clk_blink = 0;
      pause = 0; adj = 0; sel = 0;
      #1;
      model_reset();
      check("reset_async");
      cyc("reset_hold"); cyc("reset_hold");
      rst_n = 1;
      check_time("reset_state", 0, 0, 0);

      // HOLD after reset: 1 Hz edges are ignored.
      for (int i = 0; i < 3; i++) rise1("hold_ignore");
      check_time("hold_3_edges", 0, 0, 0);

      // Start running; first edge checks the two-clock latency.
      pulse_pause("start");
      cyc("start");
      clk_1hz = 1;
      cyc("lat");
      check_time("latency_1clk", 0, 0, 1);
      cyc("lat");
      check_time("latency_2clk", 0, 1, 1);
      clk_1hz = 0; cyc("lat"); cyc("lat");
      for (int i = 0; i < 60; i++) rise1("run_61");
      check_time("run_61_edges", 1, 1, 1);

      // Preload 99:59 through ADJ, then one edge in RUN wraps to 00:00.
      adj = 1; sel = 0; cyc("adj_enter");
      for (int i = 0; i < 98; i++) rise2("adj_min");
      sel = 1;
      for (int i = 0; i < 58; i++) rise2("adj_sec");
      adj = 0; cyc("adj_exit"); cyc("adj_exit");
      check_time("preload_9959", 99, 59, 1);
      rise1("wrap");
      check_time("wrap_0000", 0, 0, 1);

      // ADJ seconds without carry, then minutes wrap through MIN_MAX.
      for (int i = 0; i < 58; i++) rise1("to_58");
      check_time("at_0058", 0, 58, 1);
      adj = 1; sel = 1; cyc("adj2_enter");
      for (int i = 0; i < 3; i++) rise2("adj_sec3");
      check_time("adj_sec_nocarry", 0, 1, 0);
      sel = 0;
      for (int i = 0; i < 100; i++) rise2("adj_min100");
      check_time("adj_min_wrap", 0, 1, 0);
      adj = 0; cyc("adj2_exit"); cyc("adj2_exit");
      check_time("back_to_run", 0, 1, 1);

      // HOLD -> ADJ, pause inside ADJ flips the saved mode -> exit to RUN.
      pulse_pause("to_hold"); cyc("to_hold");
      check_time("in_hold", 0, 1, 0);
      adj = 1; cyc("adj3_enter");
      pulse_pause("adj3_pause");
      adj = 0; cyc("adj3_exit"); cyc("adj3_exit");
      check_time("adj_pause_run", 0, 1, 1);

      // Pause in the tick cycle: that tick counts, the next one does not.
      clk_1hz = 1; cyc("ptick");
      pause = 1; cyc("ptick");
      pause = 0;
      check_time("pause_tick_counts", 0, 2, 0);
      clk_1hz = 0; cyc("ptick"); cyc("ptick");
      rise1("ptick_next");
      check_time("next_tick_ignored", 0, 2, 0);

      // Blink in ADJ on minutes; blanks return to 0 on exit.
      adj = 1; sel = 0; cyc("blink_enter");
      clk_blink = 1; cyc("blink"); cyc("blink");
`ifdef BLINK_EN
      blank_exp = 4'b0010;
`else
      blank_exp = 4'b0000;
`endif
      vectors++;
      assert ({2'b00, min_blank, sec_blank} === blank_exp) else begin
         miscompares++;
         $error("FAIL blink_first_edge: observed %b%b, expected %b", min_blank, sec_blank, blank_exp[1:0]);
      end
      clk_blink = 0; cyc("blink"); cyc("blink");
      for (int i = 0; i < 3; i++) begin
         clk_blink = 1; cyc("blink"); cyc("blink");
         clk_blink = 0; cyc("blink"); cyc("blink");
      end
      adj = 0; cyc("blink_exit"); cyc("blink_exit");
      vectors++;
      assert ({min_blank, sec_blank} === 2'b00) else begin
         miscompares++;
         $error("FAIL blink_exit: observed %b%b, expected 00", min_blank, sec_blank);
      end

      // Random phase: levels toggle at random, pause is a one-cycle pulse,
      // with one asynchronous reset dropped in mid-count.
      for (int i = 0; i < 1500; i++) begin
         bit adj_n;
         if (i == 700) begin
            rst_n = 0;
            #1 model_reset();
            check("reset_mid");
            cyc("reset_mid");
            rst_n = 1;
         end
         clk_1hz   = clk_1hz   ^ ($urandom_range(0, 3) == 0);
         clk_2hz   = clk_2hz   ^ ($urandom_range(0, 2) == 0);
         clk_blink = clk_blink ^ ($urandom_range(0, 1) == 0);
         adj_n     = adj ^ ($urandom_range(0, 59) == 0);
         if (($urandom_range(0, 19) == 0)) sel = ~sel;
         pause = (!pause && adj_n == adj && $urandom_range(0, 15) == 0);
         adj   = adj_n;
         cyc("random");
      end
      pause = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
